// File: rtl/ram_result_scanner_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_result_scanner_if                                         |
// | Purpose  : Dual-port Y/Z result RAM read bus (addresses out, q back).    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface ram_result_scanner_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] Y_ADDR_A_O;
    logic [ADDR_W-1:0] Y_ADDR_B_O;
    logic [ADDR_W-1:0] Z_ADDR_A_O;
    logic [ADDR_W-1:0] Z_ADDR_B_O;
    logic [DATA_W-1:0] Y_Q_A_I;
    logic [DATA_W-1:0] Y_Q_B_I;
    logic [DATA_W-1:0] Z_Q_A_I;
    logic [DATA_W-1:0] Z_Q_B_I;

    modport master (
        output Y_ADDR_A_O, Y_ADDR_B_O, Z_ADDR_A_O, Z_ADDR_B_O,
        input  Y_Q_A_I, Y_Q_B_I, Z_Q_A_I, Z_Q_B_I
    );

    modport slave (
        input  Y_ADDR_A_O, Y_ADDR_B_O, Z_ADDR_A_O, Z_ADDR_B_O,
        output Y_Q_A_I, Y_Q_B_I, Z_Q_A_I, Z_Q_B_I
    );
endinterface
`default_nettype wire

// File: rtl/ram_result_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_result_scanner                                            |
// | Purpose  : Scans the Y/Z result RAMs through both ports and reduces them |
// |            to sums, zero count, Z maximum and an optional signature      |
// |            (signature built only when SCAN_SIGNATURE_EN is defined).     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ram_result_scanner #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int HALF   = 256,
    parameter int SUM_W  = 17
) (
    input  wire logic               CLOCK_50_I,
    input  wire logic               RESET_I,
    input  wire logic               START_I,
    output logic                    BUSY_O,
    output logic                    DONE_O,
    ram_result_scanner_if.master    ram,
    output logic [SUM_W-1:0]        Y_SUM_O,
    output logic [SUM_W-1:0]        Z_SUM_O,
    output logic [9:0]              ZERO_CNT_O,
    output logic [DATA_W-1:0]       Z_MAX_O,
    output logic [DATA_W-1:0]       SIG_O
);

    localparam int                CNT_W  = 10;
    localparam logic [ADDR_W-1:0] C_HALF = ADDR_W'(HALF);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
    logic                acc_en_q, acc_en_d;
    logic                clr_d;

    logic [SUM_W-1:0]    y_sum_q, y_sum_d;
    logic [SUM_W-1:0]    z_sum_q, z_sum_d;
    logic [CNT_W-1:0]    zero_cnt_q, zero_cnt_d;
    logic [DATA_W-1:0]   z_max_q, z_max_d;
    logic [DATA_W-1:0]   z_pair_max;

    // Sequencer: addresses and state only; data arrives one cycle behind.
    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        clr_d    = 1'b0;
        acc_en_d = (state_q == S_ISSUE);
        unique case (state_q)
            S_IDLE: begin
                if (START_I) begin
                    clr_d    = 1'b1;
                    addr_a_d = '0;
                    addr_b_d = C_HALF;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (addr_a_q == C_LAST) begin
                    addr_a_d = '0;
                    addr_b_d = C_HALF;
                    state_d  = S_DRAIN;
                end else begin
                    addr_a_d = addr_a_q + 1'b1;
                    addr_b_d = addr_b_q + 1'b1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        z_pair_max = (ram.Z_Q_A_I > ram.Z_Q_B_I) ? ram.Z_Q_A_I : ram.Z_Q_B_I;
        y_sum_d    = y_sum_q;
        z_sum_d    = z_sum_q;
        zero_cnt_d = zero_cnt_q;
        z_max_d    = z_max_q;
        if (clr_d) begin
            y_sum_d    = '0;
            z_sum_d    = '0;
            zero_cnt_d = '0;
            z_max_d    = '0;
        end else if (acc_en_q) begin
            y_sum_d    = y_sum_q + SUM_W'(ram.Y_Q_A_I) + SUM_W'(ram.Y_Q_B_I);
            z_sum_d    = z_sum_q + SUM_W'(ram.Z_Q_A_I) + SUM_W'(ram.Z_Q_B_I);
            zero_cnt_d = zero_cnt_q
                       + {{(CNT_W-1){1'b0}}, (ram.Y_Q_A_I == '0)}
                       + {{(CNT_W-1){1'b0}}, (ram.Y_Q_B_I == '0)};
            z_max_d    = (z_pair_max > z_max_q) ? z_pair_max : z_max_q;
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (RESET_I) begin
            state_q    <= S_IDLE;
            addr_a_q   <= '0;
            addr_b_q   <= C_HALF;
            acc_en_q   <= 1'b0;
            y_sum_q    <= '0;
            z_sum_q    <= '0;
            zero_cnt_q <= '0;
            z_max_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            acc_en_q   <= acc_en_d;
            y_sum_q    <= y_sum_d;
            z_sum_q    <= z_sum_d;
            zero_cnt_q <= zero_cnt_d;
            z_max_q    <= z_max_d;
        end
    end

`ifdef SCAN_SIGNATURE_EN
    logic [DATA_W-1:0] sig_q, sig_d;

    // Rotate-left then fold in the port-a Y word and port-b Z word.
    always_comb begin
        sig_d = sig_q;
        if (clr_d) begin
            sig_d = '0;
        end else if (acc_en_q) begin
            sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ ram.Y_Q_A_I ^ ram.Z_Q_B_I;
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (RESET_I) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign SIG_O = sig_q;
`else
    assign SIG_O = '0;
`endif

    assign ram.Y_ADDR_A_O = addr_a_q;
    assign ram.Y_ADDR_B_O = addr_b_q;
    assign ram.Z_ADDR_A_O = addr_a_q;
    assign ram.Z_ADDR_B_O = addr_b_q;

    assign BUSY_O     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign DONE_O     = (state_q == S_DONE);
    assign Y_SUM_O    = y_sum_q;
    assign Z_SUM_O    = z_sum_q;
    assign ZERO_CNT_O = zero_cnt_q;
    assign Z_MAX_O    = z_max_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_result_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ram_result_scanner                                         |
// | Purpose  : Scoreboard bench for ram_result_scanner with RAM model.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ram_result_scanner;

    localparam int HALF  = 256;
    localparam int WORDS = 2 * HALF;

    typedef struct {
        int start;
        int stop;
        bit aborted;
        int ys;
        int zs;
        int zc;
        int zm;
        int sig;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [16:0] ysum;
    logic [16:0] zsum;
    logic [9:0]  zcnt;
    logic [7:0]  zmax;
    logic [7:0]  sig;

    logic [7:0]  y_mem [WORDS];
    logic [7:0]  z_mem [WORDS];

    exp_t        sb[$];
    exp_t        mon_e;
    exp_t        last;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    bit          mon_busy;
    int          mon_k;

    ram_result_scanner_if #(.ADDR_W(9), .DATA_W(8)) bus ();

    ram_result_scanner dut (
        .CLOCK_50_I (clk),
        .RESET_I    (rst),
        .START_I    (start),
        .BUSY_O     (busy),
        .DONE_O     (done),
        .ram        (bus),
        .Y_SUM_O    (ysum),
        .Z_SUM_O    (zsum),
        .ZERO_CNT_O (zcnt),
        .Z_MAX_O    (zmax),
        .SIG_O      (sig)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read dual-port RAMs: q is valid the cycle after the address.
    always @(posedge clk) begin
        bus.Y_Q_A_I <= y_mem[bus.Y_ADDR_A_O];
        bus.Y_Q_B_I <= y_mem[bus.Y_ADDR_B_O];
        bus.Z_Q_A_I <= z_mem[bus.Z_ADDR_A_O];
        bus.Z_Q_B_I <= z_mem[bus.Z_ADDR_B_O];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_ysum"},  ysum, 0);
        chk({tag, "_zsum"},  zsum, 0);
        chk({tag, "_zcnt"},  zcnt, 0);
        chk({tag, "_zmax"},  zmax, 0);
        chk({tag, "_sig"},   sig, 0);
        chk({tag, "_yaa"},   bus.Y_ADDR_A_O, 0);
        chk({tag, "_yab"},   bus.Y_ADDR_B_O, HALF);
        chk({tag, "_zaa"},   bus.Z_ADDR_A_O, 0);
        chk({tag, "_zab"},   bus.Z_ADDR_B_O, HALF);
    endtask

    // Reference: whole-array statistics; signature pairs word k with word k+HALF.
    function automatic exp_t model(input int st, input bit ab, input int sp);
        exp_t       e;
        logic [7:0] s;
        e.start = st; e.aborted = ab; e.stop = sp;
        e.ys = 0; e.zs = 0; e.zc = 0; e.zm = 0;
        for (int i = 0; i < WORDS; i++) begin
            e.ys += int'(y_mem[i]);
            e.zs += int'(z_mem[i]);
            if (y_mem[i] == 8'h00) e.zc++;
            if (int'(z_mem[i]) > e.zm) e.zm = int'(z_mem[i]);
        end
        s = 8'h00;
`ifdef SCAN_SIGNATURE_EN
        for (int k = 0; k < HALF; k++) begin
            s = {s[6:0], s[7]} ^ y_mem[k] ^ z_mem[k + HALF];
        end
`endif
        e.sig = int'(s);
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                chk("busy_idle", busy, 0);
                if (done) chk("unexpected_done", done, 0);
            end else begin
                mon_e    = sb[0];
                mon_k    = cyc - mon_e.start;
                mon_busy = (cyc >= mon_e.start) && (mon_k <= HALF) &&
                           (!mon_e.aborted || cyc < mon_e.stop);
                chk("busy", busy, mon_busy);
                if (mon_busy && mon_k < HALF) begin
                    chk("y_addr_a", bus.Y_ADDR_A_O, mon_k);
                    chk("y_addr_b", bus.Y_ADDR_B_O, mon_k + HALF);
                    chk("z_addr_a", bus.Z_ADDR_A_O, mon_k);
                    chk("z_addr_b", bus.Z_ADDR_B_O, mon_k + HALF);
                end
                if (mon_e.aborted && cyc >= mon_e.stop) begin
                    chk_reset_state("abort");
                    void'(sb.pop_front());
                end else if (!mon_e.aborted && cyc >= mon_e.start + HALF + 1) begin
                    chk("done_pulse", done, 1);
                    chk("y_sum", ysum, mon_e.ys);
                    chk("z_sum", zsum, mon_e.zs);
                    chk("zero_cnt", zcnt, mon_e.zc);
                    chk("z_max", zmax, mon_e.zm);
                    chk("sig", sig, mon_e.sig);
                    last = mon_e;
                    void'(sb.pop_front());
                end else if (done) begin
                    chk("early_done", done, 0);
                end
            end
        end
    end

    task automatic fill(input int mode);
        for (int i = 0; i < WORDS; i++) begin
            case (mode)
                0: begin y_mem[i] = 8'h00; z_mem[i] = 8'h00; end
                1: begin y_mem[i] = 8'hFF; z_mem[i] = 8'hFF; end
                2: begin
                    y_mem[i] = (i == 0 || i == WORDS - 1) ? 8'h00 : 8'h01;
                    z_mem[i] = (i == 300) ? 8'h9A : 8'h01;
                end
                default: begin
                    y_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                    z_mem[i] = 8'($urandom);
                end
            endcase
        end
    endtask

    task automatic start_scan(input int abort_at, output int e_start);
        @(negedge clk);
        e_start = cyc + 1;
        start = 1'b1;
        sb.push_back(model(e_start, abort_at > 0, e_start + abort_at));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
        chk("scan_timeout", sb.size(), 0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int e;
        rst   = 1'b1;
        start = 1'b0;
        fill(0);
        repeat (3) @(negedge clk);
        chk_reset_state("por");
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        start_scan(0, e);
        wait_idle(400);

        fill(1);
        start_scan(0, e);
        wait_idle(400);
        repeat (20) @(negedge clk);
        chk("hold_ysum", ysum, last.ys);
        chk("hold_zsum", zsum, last.zs);
        chk("hold_zmax", zmax, last.zm);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_state("idle_rst");
        rst = 1'b0;

        fill(2);
        start_scan(0, e);
        wait_idle(400);

        // Ignored pulses mid-scan and in the DONE cycle, then a held START.
        start_scan(0, e);
        wait_until(e + 49);  start = 1'b1;
        @(negedge clk);      start = 1'b0;
        wait_until(e + 257); start = 1'b1;
        @(negedge clk);      start = 1'b0;
        wait_until(e + 259);
        start = 1'b1;
        for (int j = 0; j < 3; j++) sb.push_back(model(e + 260 + 259 * j, 1'b0, 0));
        wait_until(e + 260 + 518 + 5);
        start = 1'b0;
        wait_idle(1200);

        start_scan(100, e);
        wait_until(e + 99); rst = 1'b1;
        @(negedge clk);     rst = 1'b0;
        wait_idle(400);
        start_scan(0, e);
        wait_idle(400);

        for (int r = 0; r < 4; r++) begin
            fill(3);
            start_scan(0, e);
            wait_idle(400);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
